fp_mul_arbiter: RTL and testbench
=================================

# fp_mul_arbiter

Shares one AXI-Stream floating-point multiplier IP (separate A/B operand channels plus a result channel, 32-bit single precision) between up to four requesters, e.g. the PID error/gain path and the PWM duty-scaling path. Arbitration is round-robin. Each accepted operation records a requester tag in an in-order FIFO, and each multiplier result is routed back to the requester that issued it. The block sits between the control FSMs and the multiplier instance, replacing direct per-FSM connections to the IP.

## Interface
Parameters:
- NREQ, 2: number of requesters, legal range 2..4.
- TAG_DEPTH, 8: tag FIFO depth, a power of two and at least the multiplier latency + 1.

Ports:
- aclk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  operation request per requester.
- req_ready  out  NREQ  one-hot; the operands of requester i are captured in the cycle req_valid[i] && req_ready[i].
- req_a  in  32*NREQ  operand A, requester i at [32i+31:32i].
- req_b  in  32*NREQ  operand B, same packing.
- rsp_valid  out  NREQ  one-hot; a result is available for requester i.
- rsp_ready  in  NREQ  requester i accepts its result.
- rsp_data  out  32  result data, shared by all requesters, qualified by rsp_valid.
- mul_a_tvalid / mul_a_tready / mul_a_tdata  out/in/out  1/1/32  multiplier A channel.
- mul_b_tvalid / mul_b_tready / mul_b_tdata  out/in/out  1/1/32  multiplier B channel.
- mul_res_tvalid / mul_res_tready / mul_res_tdata  in/out/in  1/1/32  multiplier result channel.
- outstanding  out  $clog2(TAG_DEPTH)+1  number of issued operations whose results are not yet returned.
- err_orphan  out  1  sticky flag: a result arrived while no tag was outstanding.

## Operation
Issue FSM has two states: S_ARB and S_ISSUE.

S_ARB:
- Winner is the first i with req_valid[i], scanning from last_grant+1 modulo NREQ.
- A grant requires outstanding < TAG_DEPTH.
- On grant:
  - req_ready[winner]=1 in the same cycle (combinational).
  - Operands are latched into a_reg/b_reg.
  - The winner index is pushed into the tag FIFO.
  - last_grant <= winner.
  - a_done and b_done are cleared.
  - Next state is S_ISSUE.
- With no valid request, or with the FIFO full: stay in S_ARB, all req_ready=0.

S_ISSUE:
- mul_a_tvalid = !a_done and mul_b_tvalid = !b_done.
- Data is held stable from a_reg/b_reg.
- a_done is set on the A handshake and b_done on the B handshake; the two channels may complete in different cycles.
- When both have completed (including the same cycle), return to S_ARB.
- tdata and tvalid never change while tvalid=1 and tready=0.

Result path (independent of the FSM):
- When the FIFO is non-empty:
  - head tag h selects rsp_valid[h] = mul_res_tvalid.
  - mul_res_tready = rsp_ready[h].
  - rsp_data = mul_res_tdata.
  - The FIFO pops on a result handshake.
- When the FIFO is empty and mul_res_tvalid=1:
  - mul_res_tready=1, so the result is dropped.
  - err_orphan is set.

Boundary conditions:
- outstanding increments on push and decrements on pop; a push and pop in the same cycle leave it unchanged.
- outstanding never exceeds TAG_DEPTH and never underflows.
- FIFO pointers wrap modulo TAG_DEPTH.
- A requester dropping req_valid before it is granted is legal; no state changes.
- Results always return in issue order; the multiplier is in-order.
- Reset mid-operation:
  - The FIFO, FSM, flags and last_grant are cleared.
  - The multiplier must be reset in the same cycle by the integrator.
  - Any result that still emerges afterwards is dropped and flags err_orphan.

## Timing
Reset values:
- req_ready=0, rsp_valid=0.
- mul_a_tvalid=0, mul_b_tvalid=0, mul_res_tready=0.
- mul_a_tdata and mul_b_tdata = 0.
- outstanding=0, err_orphan=0.
- state=S_ARB, last_grant=NREQ-1, so requester 0 has first priority.

Latency and throughput:
- Request accept to mul_*_tvalid high: 1 cycle.
- Result valid to rsp_valid: 0 cycles (combinational path).
- Peak issue rate is one operation per 2 cycles when mul_*_tready are held high.

Combinational paths:
- req_ready depends on req_valid, state and outstanding.
- mul_res_tready depends on rsp_ready and the FIFO head.
- No other combinational input-to-output paths.

## Test plan
- Single requester 0 with A=2.0 (0x40000000) and B=3.0 (0x40400000) -> mul tvalid 1 cycle after accept. rsp_valid[0] with rsp_data=0x40C00000 (6.0) after the IP latency; outstanding returns to 0.
- Requesters 0 and 1 hold req_valid continuously with distinct operands -> grants alternate 0,1,0,1. Each result appears only on its own rsp_valid bit, in issue order.
- mul_a_tready=1 and mul_b_tready held 0 for 5 cycles -> a_done set after cycle 1. mul_b_tdata is stable and mul_a_tvalid=0 for those cycles. The FSM returns to S_ARB only after the B handshake.
- mul_res_tready stalled so that TAG_DEPTH=8 operations issue -> outstanding=8 and req_ready stays 0. After one result pop, exactly one new grant occurs.
- rsp_ready[1]=0 while requester 1's result is at the FIFO head -> mul_res_tready=0 and the result is held. Requester 0's later result is not delivered until requester 1 accepts.
- rst asserted in S_ISSUE with 3 outstanding, then a stray result injected -> all outputs return to reset values, the stray result is dropped, and err_orphan=1 until the next reset.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one AXI-Stream FP multiplier between NREQ requesters.
// Each issued operation pushes its requester tag into an in-order FIFO; results are steered back by the head tag.
module fp_mul_arbiter #(
  parameter int NREQ      = 2,
  parameter int TAG_DEPTH = 8
) (
  input  logic                          aclk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [32*NREQ-1:0]            req_a,
  input  logic [32*NREQ-1:0]            req_b,
  output logic [NREQ-1:0]               rsp_valid,
  input  logic [NREQ-1:0]               rsp_ready,
  output logic [31:0]                   rsp_data,
  output logic                          mul_a_tvalid,
  input  logic                          mul_a_tready,
  output logic [31:0]                   mul_a_tdata,
  output logic                          mul_b_tvalid,
  input  logic                          mul_b_tready,
  output logic [31:0]                   mul_b_tdata,
  input  logic                          mul_res_tvalid,
  output logic                          mul_res_tready,
  input  logic [31:0]                   mul_res_tdata,
  output logic [$clog2(TAG_DEPTH):0]    outstanding,
  output logic                          err_orphan
);

  localparam int DATA_W = 32;
  localparam int PW     = $clog2(TAG_DEPTH);
  localparam int CW     = PW + 1;
  localparam int GW     = $clog2(NREQ);

  localparam logic [0:0] S_ARB   = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]        state;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     winner;
  logic [GW-1:0]     cand;
  logic [GW-1:0]     head_tag;
  logic              found;
  logic              grant;
  logic              a_done;
  logic              b_done;
  logic              a_hs;
  logic              b_hs;
  logic              empty;
  logic              pop;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [GW-1:0]     tag_mem [TAG_DEPTH];

  // Round-robin scan starting just after the previous winner
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant = (state == S_ARB) && found && (outstanding < CW'(TAG_DEPTH));

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (winner == GW'(i));
    end
  end

  assign mul_a_tvalid = (state == S_ISSUE) && !a_done;
  assign mul_b_tvalid = (state == S_ISSUE) && !b_done;
  assign mul_a_tdata  = mul_a_tvalid ? a_reg : '0;
  assign mul_b_tdata  = mul_b_tvalid ? b_reg : '0;
  assign a_hs         = mul_a_tvalid && mul_a_tready;
  assign b_hs         = mul_b_tvalid && mul_b_tready;

  // Result steering: an empty FIFO means nobody owns the result, so it is swallowed
  assign empty    = (outstanding == '0);
  assign head_tag = tag_mem[rd_ptr];
  assign rsp_data = mul_res_tdata;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = !empty && mul_res_tvalid && (head_tag == GW'(i));
    end
  end

  assign mul_res_tready = empty ? mul_res_tvalid : rsp_ready[head_tag];
  assign pop            = !empty && mul_res_tvalid && mul_res_tready;

  always_ff @(posedge aclk) begin
    if (rst) begin
      state       <= S_ARB;
      last_grant  <= GW'(NREQ - 1);
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      err_orphan  <= 1'b0;
    end else begin
      case (state)
        S_ARB: begin
          if (grant) begin
            state      <= S_ISSUE;
            last_grant <= winner;
            a_done     <= 1'b0;
            b_done     <= 1'b0;
          end
        end
        default: begin
          a_done <= a_done || a_hs;
          b_done <= b_done || b_hs;
          if ((a_done || a_hs) && (b_done || b_hs)) begin
            state <= S_ARB;
          end
        end
      endcase

      if (grant) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({grant, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (empty && mul_res_tvalid) begin
        err_orphan <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (grant) begin
      a_reg            <= req_a[int'(winner)*DATA_W +: DATA_W];
      b_reg            <= req_b[int'(winner)*DATA_W +: DATA_W];
      tag_mem[wr_ptr]  <= winner;
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a behavioural fixed-latency in-order multiplier.
module tb_fp_mul_arbiter;
  localparam int NREQ = 2;
  localparam int TAG_DEPTH = 8;
  localparam int LAT = 3;

  logic aclk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [32*NREQ-1:0] req_a, req_b;
  logic [31:0] rsp_data;
  logic mul_a_tvalid, mul_a_tready, mul_b_tvalid, mul_b_tready;
  logic [31:0] mul_a_tdata, mul_b_tdata;
  logic mul_res_tvalid, mul_res_tready;
  logic [31:0] mul_res_tdata;
  logic [3:0] outstanding;
  logic err_orphan;

  logic a_stall, b_stall, res_stall, inj_v;
  logic [31:0] inj_d;
  logic a_have, b_have, model_valid;
  logic [31:0] a_hold, b_hold;
  logic [31:0] rmem [16];
  int due [16];
  int wp, rp;
  int cyc = 0;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  fp_mul_arbiter #(.NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH)) dut (
    .aclk(aclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mul_a_tvalid(mul_a_tvalid), .mul_a_tready(mul_a_tready), .mul_a_tdata(mul_a_tdata),
    .mul_b_tvalid(mul_b_tvalid), .mul_b_tready(mul_b_tready), .mul_b_tdata(mul_b_tdata),
    .mul_res_tvalid(mul_res_tvalid), .mul_res_tready(mul_res_tready), .mul_res_tdata(mul_res_tdata),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  // Exact for normal operands whose product mantissa fits; enough for the chosen vectors
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [8:0] e;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 9'(a[30:23]) + 9'(b[30:23]) - 9'd127;
    if (p[47]) begin
      e = e + 9'd1;
      p = p >> 1;
    end
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  assign mul_a_tready   = !a_have && !a_stall;
  assign mul_b_tready   = !b_have && !b_stall;
  assign model_valid    = (wp != rp) && (due[rp % 16] <= cyc) && !res_stall;
  assign mul_res_tvalid = inj_v || model_valid;
  assign mul_res_tdata  = inj_v ? inj_d : rmem[rp % 16];

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (rst) begin
      a_have <= 1'b0;
      b_have <= 1'b0;
      wp <= 0;
      rp <= 0;
    end else begin
      if (mul_a_tvalid && mul_a_tready) begin
        a_have <= 1'b1;
        a_hold <= mul_a_tdata;
      end
      if (mul_b_tvalid && mul_b_tready) begin
        b_have <= 1'b1;
        b_hold <= mul_b_tdata;
      end
      if (a_have && b_have) begin
        rmem[wp % 16] <= fmul(a_hold, b_hold);
        due[wp % 16] <= cyc + LAT;
        wp <= wp + 1;
        a_have <= 1'b0;
        b_have <= 1'b0;
      end
      if (!inj_v && model_valid && mul_res_tready) rp <= rp + 1;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    inj_v = 1'b0;
    a_stall = 1'b0;
    b_stall = 1'b0;
    res_stall = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    rsp_ready = '1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (outstanding == 4'd0) begin
        ok = 1'b1;
        break;
      end
      if (rsp_valid != '0) n++;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    rsp_ready = '0;
    #1;
    tests++;
    if ({req_ready, rsp_valid, mul_a_tvalid, mul_b_tvalid, mul_res_tready, err_orphan} !== 8'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {req_ready, rsp_valid, mul_a_tvalid, mul_b_tvalid, mul_res_tready, err_orphan});
    end
    tests++;
    if ({mul_a_tdata, mul_b_tdata, outstanding} !== 68'd0) begin
      fails++;
      $display("FAIL reset_data: a=%h b=%h outstanding=%0d required 0", mul_a_tdata, mul_b_tdata, outstanding);
    end
    req_valid = 2'b11;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL reset_priority: req_ready=%b required 01", req_ready);
    end
    req_valid = 2'b00;
    #1;
    tests++;
    if (req_ready !== 2'b00) begin
      fails++;
      $display("FAIL reset_drop: req_ready=%b required 00", req_ready);
    end
  endtask

  task automatic test_single();
    bit seen;
    do_reset();
    rsp_ready = 2'b11;
    req_a = {32'h0, 32'h40000000};
    req_b = {32'h0, 32'h40400000};
    req_valid = 2'b01;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL single_accept: req_ready=%b required 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tests++;
    if ({mul_a_tvalid, mul_b_tvalid, mul_a_tdata, mul_b_tdata, outstanding} !==
        {2'b11, 32'h40000000, 32'h40400000, 4'd1}) begin
      fails++;
      $display("FAIL single_issue: tvalid=%b%b a=%h b=%h outstanding=%0d required 11 40000000 40400000 1",
               mul_a_tvalid, mul_b_tvalid, mul_a_tdata, mul_b_tdata, outstanding);
    end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid != '0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!seen || rsp_valid !== 2'b01 || rsp_data !== 32'h40C00000) begin
      fails++;
      $display("FAIL single_result: seen=%0d rsp_valid=%b data=%h required 01 40c00000", seen, rsp_valid, rsp_data);
    end
    tick();
    tests++;
    if (outstanding !== 4'd0) begin
      fails++;
      $display("FAIL single_outstanding: got %0d required 0", outstanding);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] g [4];
    logic [1:0] rv [4];
    logic [31:0] rd [4];
    logic [1:0] eg [4];
    logic [31:0] ed [4];
    int ng, nr;
    eg = '{2'b01, 2'b10, 2'b01, 2'b10};
    ed = '{32'h40800000, 32'h40400000, 32'h40800000, 32'h40400000};
    for (int k = 0; k < 4; k++) begin
      g[k] = '0;
      rv[k] = '0;
      rd[k] = '0;
    end
    do_reset();
    rsp_ready = 2'b11;
    req_a = {32'h3FC00000, 32'h40000000};
    req_b = {32'h40000000, 32'h40000000};
    req_valid = 2'b11;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 60 && nr < 4; c++) begin
      #1;
      if (ng < 4 && req_ready != '0) begin
        g[ng] = req_ready;
        ng++;
      end
      if (rsp_valid != '0) begin
        rv[nr] = rsp_valid;
        rd[nr] = rsp_data;
        nr++;
      end
      tick();
      if (ng == 4) req_valid = '0;
    end
    tests++;
    if (nr != 4) begin
      fails++;
      $display("FAIL alt_timeout: results=%0d required 4", nr);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (g[k] !== eg[k] || rv[k] !== eg[k] || rd[k] !== ed[k]) begin
        fails++;
        $display("FAIL alt_%0d: grant=%b rsp_valid=%b data=%h required %b %b %h",
                 k, g[k], rv[k], rd[k], eg[k], eg[k], ed[k]);
      end
    end
  endtask

  task automatic test_b_stall();
    int n;
    bit ok;
    do_reset();
    rsp_ready = 2'b11;
    b_stall = 1'b1;
    req_a = {32'h3F800000, 32'h40000000};
    req_b = {32'h40000000, 32'h40400000};
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b10;
    tick();
    for (int k = 0; k < 5; k++) begin
      tests++;
      if ({mul_a_tvalid, mul_b_tvalid, req_ready, mul_b_tdata} !== {1'b0, 1'b1, 2'b00, 32'h40400000}) begin
        fails++;
        $display("FAIL bstall_hold_%0d: a_tvalid=%b b_tvalid=%b req_ready=%b b_tdata=%h required 0 1 00 40400000",
                 k, mul_a_tvalid, mul_b_tvalid, req_ready, mul_b_tdata);
      end
      tick();
    end
    b_stall = 1'b0;
    #1;
    tests++;
    if ({req_ready, mul_b_tvalid} !== 3'b001) begin
      fails++;
      $display("FAIL bstall_release: req_ready=%b b_tvalid=%b required 00 1", req_ready, mul_b_tvalid);
    end
    tick();
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("FAIL bstall_rearb: req_ready=%b required 10", req_ready);
    end
    tick();
    req_valid = '0;
    drain(n, ok);
    tests++;
    if (!ok || outstanding !== 4'd0) begin
      fails++;
      $display("FAIL bstall_drain: ok=%0d outstanding=%0d required 1 0", ok, outstanding);
    end
  endtask

  task automatic test_full();
    int ng, n;
    bit ok;
    do_reset();
    rsp_ready = 2'b11;
    res_stall = 1'b1;
    req_a = {32'h0, 32'h3F800000};
    req_b = {32'h0, 32'h3F800000};
    req_valid = 2'b01;
    ng = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (req_ready != '0) ng++;
      tick();
    end
    #1;
    tests++;
    if (ng != 8 || outstanding !== 4'd8 || req_ready !== 2'b00) begin
      fails++;
      $display("FAIL full_stop: grants=%0d outstanding=%0d req_ready=%b required 8 8 00", ng, outstanding, req_ready);
    end
    res_stall = 1'b0;
    #1;
    tests++;
    if ({rsp_valid, mul_res_tready, rsp_data} !== {2'b01, 1'b1, 32'h3F800000}) begin
      fails++;
      $display("FAIL full_pop: rsp_valid=%b res_tready=%b data=%h required 01 1 3f800000",
               rsp_valid, mul_res_tready, rsp_data);
    end
    tick();
    res_stall = 1'b1;
    #1;
    tests++;
    if ({outstanding, req_ready} !== {4'd7, 2'b01}) begin
      fails++;
      $display("FAIL full_regrant: outstanding=%0d req_ready=%b required 7 01", outstanding, req_ready);
    end
    tick();
    ng = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != '0) ng++;
      tick();
    end
    tests++;
    if (ng != 0 || outstanding !== 4'd8) begin
      fails++;
      $display("FAIL full_single_grant: extra_grants=%0d outstanding=%0d required 0 8", ng, outstanding);
    end
    req_valid = '0;
    res_stall = 1'b0;
    drain(n, ok);
    tests++;
    if (!ok || n != 8 || err_orphan !== 1'b0) begin
      fails++;
      $display("FAIL full_drain: ok=%0d results=%0d err_orphan=%b required 1 8 0", ok, n, err_orphan);
    end
  endtask

  task automatic test_hold();
    do_reset();
    rsp_ready = 2'b01;
    req_a = {32'h40000000, 32'h3F000000};
    req_b = {32'h40000000, 32'h40800000};
    req_valid = 2'b10;
    #1;
    tick();
    req_valid = 2'b01;
    for (int c = 0; c < 10; c++) begin
      if (outstanding == 4'd2) break;
      tick();
    end
    req_valid = '0;
    tests++;
    if (outstanding !== 4'd2) begin
      fails++;
      $display("FAIL hold_issue: outstanding=%0d required 2", outstanding);
    end
    for (int c = 0; c < 8; c++) tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({rsp_valid, mul_res_tready, rsp_data, outstanding} !== {2'b10, 1'b0, 32'h40800000, 4'd2}) begin
        fails++;
        $display("FAIL hold_stall_%0d: rsp_valid=%b res_tready=%b data=%h outstanding=%0d required 10 0 40800000 2",
                 k, rsp_valid, mul_res_tready, rsp_data, outstanding);
      end
      tick();
    end
    rsp_ready = 2'b11;
    #1;
    tests++;
    if (mul_res_tready !== 1'b1) begin
      fails++;
      $display("FAIL hold_accept: res_tready=%b required 1", mul_res_tready);
    end
    tick();
    tests++;
    if ({rsp_valid, rsp_data} !== {2'b01, 32'h40000000}) begin
      fails++;
      $display("FAIL hold_second: rsp_valid=%b data=%h required 01 40000000", rsp_valid, rsp_data);
    end
    tick();
    tests++;
    if (outstanding !== 4'd0) begin
      fails++;
      $display("FAIL hold_done: outstanding=%0d required 0", outstanding);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    do_reset();
    rsp_ready = 2'b11;
    res_stall = 1'b1;
    req_a = {32'h0, 32'h3F800000};
    req_b = {32'h0, 32'h3F800000};
    req_valid = 2'b01;
    for (int c = 0; c < 20; c++) begin
      if (outstanding == 4'd3) break;
      tick();
    end
    req_valid = '0;
    tests++;
    if ({outstanding, mul_a_tvalid} !== {4'd3, 1'b1}) begin
      fails++;
      $display("FAIL rmid_setup: outstanding=%0d a_tvalid=%b required 3 1", outstanding, mul_a_tvalid);
    end
    rst = 1'b1;
    tick();
    tests++;
    if ({req_ready, rsp_valid, mul_a_tvalid, mul_b_tvalid, mul_res_tready, outstanding, err_orphan, mul_a_tdata} !== '0) begin
      fails++;
      $display("FAIL rmid_reset: ctrl=%b outstanding=%0d err=%b a_tdata=%h required all 0",
               {req_ready, rsp_valid, mul_a_tvalid, mul_b_tvalid, mul_res_tready}, outstanding, err_orphan, mul_a_tdata);
    end
    tick();
    rst = 1'b0;
    res_stall = 1'b0;
    inj_v = 1'b1;
    inj_d = 32'h12345678;
    #1;
    tests++;
    if ({mul_res_tready, rsp_valid} !== 3'b100) begin
      fails++;
      $display("FAIL rmid_drop: res_tready=%b rsp_valid=%b required 1 00", mul_res_tready, rsp_valid);
    end
    tick();
    inj_v = 1'b0;
    tests++;
    if ({err_orphan, outstanding} !== {1'b1, 4'd0}) begin
      fails++;
      $display("FAIL rmid_orphan: err_orphan=%b outstanding=%0d required 1 0", err_orphan, outstanding);
    end
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = '0;
    drain(n, ok);
    tests++;
    if (!ok || n != 1 || err_orphan !== 1'b1) begin
      fails++;
      $display("FAIL rmid_sticky: ok=%0d results=%0d err_orphan=%b required 1 1 1", ok, n, err_orphan);
    end
    do_reset();
    #1;
    tests++;
    if (err_orphan !== 1'b0) begin
      fails++;
      $display("FAIL rmid_clear: err_orphan=%b required 0", err_orphan);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '0;
    a_stall = 1'b0;
    b_stall = 1'b0;
    res_stall = 1'b0;
    inj_v = 1'b0;
    inj_d = '0;
    test_reset();
    test_single();
    test_alternate();
    test_b_stall();
    test_full();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
